memory_stage: RTL and testbench

Memory-access stage of the 16-bit pipelined CPU, directly downstream of the execute pipeline register and ALU. It latches the execute-stage results into the EX/MEM register and drives a handshaked data-memory port for load/store instructions. It stalls upstream stages while a memory access is outstanding and hands results to write-back through a MEM/WB register.

---
 rtl/memory_stage.sv | 150 +++++++++++++++
 tb/tb_memory_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory-access stage of the 16-bit pipelined CPU.
// Holds the EX/MEM register, runs a two-state request FSM against a
// handshaked data memory, stalls upstream while an access is pending and
// feeds the MEM/WB register.
//
// Memory handshake: memReq is high for every cycle spent in WAIT and the
// request fields (memWe/memAddr/memWdata) are driven from the frozen M
// register, so they are stable for the whole request. memAck completes the
// access in the cycle it is seen high together with memReq (it may arrive
// combinationally in the first request cycle); memAck outside WAIT is ignored.
module memory_stage #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              MemToRegE,
  input  logic [15:0]       aluResultE,
  input  logic [15:0]       writeDataE,
  input  logic [3:0]        destAddE,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [15:0]       memWdata,
  input  logic [15:0]       memRdata,
  input  logic              memAck,
  output logic              stallM,
  output logic              RegWriteW,
  output logic              MemToRegW,
  output logic [15:0]       aluResultW,
  output logic [15:0]       readDataW,
  output logic [3:0]        destAddW,
  output logic              memErr
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  // EX/MEM register
  logic        reg_write_m, mem_write_m, mem_to_reg_m;
  logic [15:0] alu_result_m, write_data_m;
  logic [3:0]  dest_add_m;

  logic        mem_op_e;
  logic        in_wait;
  logic        ack_hit;
  logic        timeout_hit;
  logic        load_m;
  logic        stall;

  assign mem_op_e    = MemWriteE | MemToRegE;
  assign in_wait     = (state_q == ST_WAIT);
  assign ack_hit     = in_wait & memAck;
  assign timeout_hit = in_wait & ~memAck & (wait_cnt_q == 8'(TIMEOUT - 1));
  // A store wins when both memory controls are set.
  assign load_m      = mem_to_reg_m & ~mem_write_m;

  // Next-state logic and stall generation for the request FSM
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wait_cnt_d = 8'd0;
        if (mem_op_e) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (memAck || timeout_hit) begin
          wait_cnt_d = 8'd0;
          state_d    = mem_op_e ? ST_WAIT : ST_IDLE;
        end else begin
          stall      = 1'b1;
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  assign stallM   = stall;
  assign memReq   = in_wait;
  assign memWe    = in_wait & mem_write_m;
  assign memAddr  = in_wait ? alu_result_m[ADDR_W-1:0] : '0;
  assign memWdata = in_wait ? write_data_m : 16'd0;

  // FSM state register and wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // EX/MEM register: frozen while the stage stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      alu_result_m <= 16'd0;
      write_data_m <= 16'd0;
      dest_add_m   <= 4'd0;
    end else if (!stall) begin
      reg_write_m  <= RegWriteE;
      mem_write_m  <= MemWriteE;
      mem_to_reg_m <= MemToRegE;
      alu_result_m <= aluResultE;
      write_data_m <= writeDataE;
      dest_add_m   <= destAddE;
    end
  end

  // MEM/WB register: bubble while stalled, retire otherwise; aborted loads do not write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteW  <= 1'b0;
      MemToRegW  <= 1'b0;
      aluResultW <= 16'd0;
      readDataW  <= 16'd0;
      destAddW   <= 4'd0;
    end else if (stall) begin
      RegWriteW  <= 1'b0;
      MemToRegW  <= 1'b0;
    end else begin
      RegWriteW  <= reg_write_m & ~timeout_hit;
      MemToRegW  <= load_m;
      aluResultW <= alu_result_m;
      readDataW  <= (ack_hit && load_m) ? memRdata : 16'd0;
      destAddW   <= dest_add_m;
    end
  end

  // One-cycle error pulse after an aborted access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) memErr <= 1'b0;
    else        memErr <= timeout_hit;
  end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus random instruction streams,
// checked cycle by cycle against an instruction-level model of the stage.
module tb_memory_stage;

  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rw_e = 1'b0, mw_e = 1'b0, mtr_e = 1'b0;
  logic [15:0]       alu_e = '0, wd_e = '0;
  logic [3:0]        dest_e = '0;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata = '0;
  logic              mem_ack = 1'b0;
  logic              stall_m;
  logic              rw_w, mtr_w;
  logic [15:0]       alu_w, rd_w;
  logic [3:0]        dest_w;
  logic              mem_err;

  memory_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .RegWriteE(rw_e), .MemWriteE(mw_e), .MemToRegE(mtr_e),
    .aluResultE(alu_e), .writeDataE(wd_e), .destAddE(dest_e),
    .memReq(mem_req), .memWe(mem_we), .memAddr(mem_addr), .memWdata(mem_wdata),
    .memRdata(mem_rdata), .memAck(mem_ack), .stallM(stall_m),
    .RegWriteW(rw_w), .MemToRegW(mtr_w), .aluResultW(alu_w),
    .readDataW(rd_w), .destAddW(dest_w), .memErr(mem_err)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // lat: request cycle (0-based) in which the memory acks; >= TIMEOUT never acks
  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        mtr;
    logic [15:0] alu;
    logic [15:0] wd;
    logic [3:0]  dest;
    logic [7:0]  lat;
  } instr_t;

  int checks = 0;
  int errors = 0;

  instr_t      pend_q[$];
  // expected W/err after each edge: {err, rw, mtr, dest, alu, rdata}
  logic [38:0] exp_q[$];
  instr_t      cur;
  int          cur_r;
  logic [15:0] last_alu, last_rd;
  logic [3:0]  last_dest;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic rw, input logic mw, input logic mtr,
                                input logic [15:0] alu, input logic [15:0] wd,
                                input logic [3:0] dest, input logic [7:0] lat);
    instr_t t;
    t.rw = rw; t.mw = mw; t.mtr = mtr; t.alu = alu; t.wd = wd; t.dest = dest; t.lat = lat;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    int kind;
    kind   = $urandom_range(0, 4);
    t      = '0;
    t.alu  = 16'($urandom);
    t.wd   = 16'($urandom);
    t.dest = 4'($urandom);
    t.lat  = 8'($urandom_range(0, TIMEOUT + 1));
    case (kind)
      1: t.rw = 1'b1;
      2: begin t.rw = 1'b1; t.mtr = 1'b1; end
      3: t.mw = 1'b1;
      4: begin t.mw = 1'b1; t.mtr = 1'b1; t.rw = 1'($urandom); end
      default: ;
    endcase
    return t;
  endfunction

  task automatic model_reset();
    cur       = '0;
    cur_r     = 0;
    last_alu  = '0;
    last_rd   = '0;
    last_dest = '0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  // One clock cycle: check previous edge, drive this cycle, check request side, predict.
  task automatic step();
    logic [38:0] e;
    instr_t      nxt;
    logic        is_mem, ack, done, t_rw, t_mtr;
    logic [15:0] rd, t_rd;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("memErr",     32'(mem_err), 32'(e[38]));
      check("RegWriteW",  32'(rw_w),    32'(e[37]));
      check("MemToRegW",  32'(mtr_w),   32'(e[36]));
      check("destAddW",   32'(dest_w),  32'(e[35:32]));
      check("aluResultW", 32'(alu_w),   32'(e[31:16]));
      check("readDataW",  32'(rd_w),    32'(e[15:0]));
    end
    is_mem    = cur.mw | cur.mtr;
    ack       = is_mem && (cur_r == int'(cur.lat));
    rd        = 16'($urandom);
    mem_rdata = rd;
    mem_ack   = is_mem ? ack : 1'($urandom);
    done      = !is_mem || ack || (cur_r == TIMEOUT - 1);
    if (done) begin
      nxt = '0;
      if (pend_q.size() > 0) nxt = pend_q.pop_front();
      rw_e = nxt.rw; mw_e = nxt.mw; mtr_e = nxt.mtr;
      alu_e = nxt.alu; wd_e = nxt.wd; dest_e = nxt.dest;
    end else begin
      nxt = cur;
      rw_e = 1'($urandom); mw_e = 1'($urandom); mtr_e = 1'($urandom);
      alu_e = 16'($urandom); wd_e = 16'($urandom); dest_e = 4'($urandom);
    end
    #1;
    check("memReq", 32'(mem_req), 32'(is_mem));
    check("stallM", 32'(stall_m), 32'(is_mem && !done));
    if (is_mem) begin
      check("memWe",    32'(mem_we),    32'(cur.mw));
      check("memAddr",  32'(mem_addr),  32'(cur.alu[ADDR_W-1:0]));
      check("memWdata", 32'(mem_wdata), 32'(cur.wd));
    end
    if (done) begin
      t_mtr     = cur.mtr & ~cur.mw;
      t_rw      = (is_mem && !ack) ? 1'b0 : cur.rw;
      t_rd      = (is_mem && ack && t_mtr) ? rd : 16'd0;
      last_alu  = cur.alu;
      last_dest = cur.dest;
      last_rd   = t_rd;
      exp_q.push_back({is_mem && !ack, t_rw, t_mtr, last_dest, last_alu, last_rd});
      cur   = nxt;
      cur_r = 0;
    end else begin
      exp_q.push_back({1'b0, 1'b0, 1'b0, last_dest, last_alu, last_rd});
      cur_r++;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((pend_q.size() > 0 || cur.mw || cur.mtr) && guard < 5000) begin
      step();
      guard++;
    end
    check("drain_budget", 32'(guard < 5000), 32'd1);
    step();
    step();
  endtask

  initial begin
    // reset state
    #12;
    check("rst_memReq", 32'(mem_req), 32'd0);
    check("rst_memWe", 32'(mem_we), 32'd0);
    check("rst_memAddr", 32'(mem_addr), 32'd0);
    check("rst_memWdata", 32'(mem_wdata), 32'd0);
    check("rst_stallM", 32'(stall_m), 32'd0);
    check("rst_memErr", 32'(mem_err), 32'd0);
    check("rst_W", {rw_w, mtr_w, dest_w, alu_w[9:0], rd_w}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // ALU op, 3-cycle load, store+load back-to-back with same-cycle ack, timeout, ALU op
    pend_q.push_back(mk(1, 0, 0, 16'h1234, 16'h0000, 4'h5, 8'd0));
    pend_q.push_back(mk(1, 0, 1, 16'h0ABC, 16'h0000, 4'h3, 8'd2));
    pend_q.push_back(mk(0, 1, 0, 16'h0010, 16'h00FF, 4'h0, 8'd0));
    pend_q.push_back(mk(1, 0, 1, 16'h0010, 16'h0000, 4'h7, 8'd0));
    pend_q.push_back(mk(1, 0, 1, 16'h0444, 16'h0000, 4'h9, 8'd255));
    pend_q.push_back(mk(1, 0, 0, 16'h5678, 16'h0000, 4'hA, 8'd0));
    pend_q.push_back(mk(1, 1, 1, 16'h0F0F, 16'hA5A5, 4'h2, 8'd1));
    drain();

    // random instruction stream
    for (int i = 0; i < 300; i++) pend_q.push_back(rand_instr());
    drain();

    // reset while a load waits for its ack
    pend_q.push_back(mk(1, 0, 1, 16'h0321, 16'h0000, 4'h6, 8'd255));
    step();
    step();
    @(negedge clk);
    #2;
    reset = 1'b0;
    rw_e = 1'b0; mw_e = 1'b0; mtr_e = 1'b0; alu_e = '0; wd_e = '0; dest_e = '0;
    mem_ack = 1'b0;
    #1;
    check("midrst_memReq", 32'(mem_req), 32'd0);
    check("midrst_stallM", 32'(stall_m), 32'd0);
    check("midrst_memErr", 32'(mem_err), 32'd0);
    check("midrst_W", {rw_w, mtr_w, dest_w, alu_w[9:0], rd_w}, 32'd0);
    check("midrst_Whi", 32'(alu_w[15:10]), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    pend_q.push_back(mk(1, 0, 0, 16'hCAFE, 16'h0000, 4'hC, 8'd0));
    pend_q.push_back(mk(1, 0, 1, 16'h0777, 16'h0000, 4'h1, 8'd1));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
